// File: rtl/switch_debounce3.sv
// switch_debounce3
// Three-channel switch conditioner for the a/b/c inputs of the NAND gate stage.
// Each channel has a two-flop synchronizer and a stability counter, so a new
// level is accepted only after it has been seen for STABLE_CYCLES consecutive
// synchronized samples. Registered rise/fall strobes mark each accepted change,
// and a settled flag reports when no channel has a change still qualifying.
// Channels share no state.

module switch_debounce3 #(
    parameter int STABLE_CYCLES = 16,  // legal range 1 .. 2**CNT_W
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] rise,
    output logic [2:0] fall,
    output logic       stable
);

    localparam int NCH = 3;

    // Terminal count: once a channel has disagreed for this many previous
    // samples, the current disagreeing sample completes the qualification.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [NCH-1:0]            sync0_q;
    logic [NCH-1:0]            sync1_q;
    logic [NCH-1:0]            level_q;
    logic [NCH-1:0]            level_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_d;
    logic [NCH-1:0]            rise_q;
    logic [NCH-1:0]            rise_d;
    logic [NCH-1:0]            fall_q;
    logic [NCH-1:0]            fall_d;

    // Two-flop synchronizer that brings the raw switch levels into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let sync1_q take the old sync0_q,
            // which is what makes this a two-stage pipeline.
            sync0_q <= sw_in;
            sync1_q <= sync0_q;
        end
    end

    // Per-channel qualification. Any agreement with the current level restarts the count.
    always_comb begin
        // NOTE: each output gets a default before the loop. Without these
        // defaults, a path that does not assign a value would infer a latch.
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync1_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync1_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync1_q[i];
                fall_d[i]  = ~sync1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounced levels, counters and strobes. The strobes share the edge where the level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign a    = level_q[0];
    assign b    = level_q[1];
    assign c    = level_q[2];
    assign rise = rise_q;
    assign fall = fall_q;

    // Settled only when every counter is idle and every synchronized input
    // matches its level. This is decoded from registers, so there is no path from sw_in.
    assign stable = (cnt_q == '0) && (sync1_q == level_q);

endmodule

// File: tb/tb_switch_debounce3.sv
// Testbench for switch_debounce3 with STABLE_CYCLES=4 and CNT_W=3.
// A reference model keeps a short history of the sampled inputs. It accepts a
// new level when the last STABLE_CYCLES synchronized samples all disagree with
// the current level. Each clock it pushes the expected outputs into a queue,
// and a monitor on the falling edge pops each entry and compares it with the DUT.

module tb_switch_debounce3;

    localparam int S    = 4;
    localparam int CW   = 3;
    localparam int HLEN = 64;

    typedef struct packed {
        logic [2:0] level;
        logic [2:0] rise;
        logic [2:0] fall;
        logic       stable;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw_in;
    logic       a;
    logic       b;
    logic       c;
    logic [2:0] rise;
    logic [2:0] fall;
    logic       stable;

    int total;
    int bad;

    exp_t exp_q[$];

    switch_debounce3 #(
        .STABLE_CYCLES(S),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_in (sw_in),
        .a     (a),
        .b     (b),
        .c     (c),
        .rise  (rise),
        .fall  (fall),
        .stable(stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[e % HLEN] holds sw_in as sampled at post-reset edge e. Samples
    // before the first post-reset edge read as 0.
    logic [2:0] hist [HLEN];
    int         n_edge;
    logic [2:0] m_level;

    function automatic logic [2:0] sample_at(input int idx);
        if (idx < 1) return 3'b000;
        return hist[idx % HLEN];
    endfunction

    logic [2:0] m_rise, m_fall, w_smp, prev_smp, now_smp;
    logic       m_stable, all_diff, old_lvl;

    always @(posedge clk) begin
        if (!rst_n) begin
            n_edge  = 0;
            m_level = 3'b000;
            exp_q.push_back('{level: 3'b000, rise: 3'b000, fall: 3'b000, stable: 1'b1});
        end else begin
            n_edge++;
            hist[n_edge % HLEN] = sw_in;
            m_rise   = 3'b000;
            m_fall   = 3'b000;
            m_stable = 1'b1;
            // At edge n, the synchronized value in use is the sample taken at edge n-2.
            prev_smp = sample_at(n_edge - 2);
            now_smp  = sample_at(n_edge - 1);
            for (int ch = 0; ch < 3; ch++) begin
                old_lvl  = m_level[ch];
                all_diff = 1'b1;
                for (int j = n_edge - S - 1; j <= n_edge - 2; j++) begin
                    w_smp = sample_at(j);
                    if (w_smp[ch] == old_lvl) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[ch] = ~old_lvl;
                    m_rise[ch]  = ~old_lvl;
                    m_fall[ch]  = old_lvl;
                end
                // Settled: the count is idle after this edge and the next
                // synchronized value agrees with the level.
                if (!((prev_smp[ch] == old_lvl) || all_diff) || (now_smp[ch] != m_level[ch]))
                    m_stable = 1'b0;
            end
            exp_q.push_back('{level: m_level, rise: m_rise, fall: m_fall, stable: m_stable});
        end
    end

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("level_cba", {29'd0, c, b, a}, {29'd0, got.level});
            check("rise",      {29'd0, rise},    {29'd0, got.rise});
            check("fall",      {29'd0, fall},    {29'd0, got.fall});
            check("stable",    {31'd0, stable},  {31'd0, got.stable});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Assert reset mid-cycle, check that the reset values appear at once,
    // then release after the next rising edge.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_levels", {29'd0, c, b, a}, 32'd0);
        check("rst_rise",   {29'd0, rise},    32'd0);
        check("rst_fall",   {29'd0, fall},    32'd0);
        check("rst_stable", {31'd0, stable},  32'd1);
        step(1);
        rst_n = 1'b1;
    endtask

    int         hold [3];
    logic [2:0] rnd_v;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sw_in = 3'b000;
        step(3);
        rst_n = 1'b1;

        // Release with all switches low: no strobes, and stable stays high.
        step(8);

        // Simultaneous rise on all three channels.
        sw_in = 3'b111;
        step(10);

        // Only channel 0 falls.
        sw_in = 3'b110;
        step(10);

        // Bounce on channel 1: 3 cycles high, 2 cycles low, repeated for 30 cycles.
        sw_in = 3'b000;
        step(10);
        for (int p = 0; p < 6; p++) begin
            sw_in = 3'b010;
            step(3);
            sw_in = 3'b000;
            step(2);
        end
        step(10);

        // Reset while channel 2 is qualifying, with the switch still held after release.
        sw_in = 3'b100;
        step(3);
        reset_pulse();
        step(12);

        // Staggered channels.
        sw_in = 3'b000;
        step(10);
        sw_in = 3'b001;
        step(2);
        sw_in = 3'b101;
        step(12);

        // Random hold lengths per channel mix glitches with qualified changes.
        for (int ch = 0; ch < 3; ch++) hold[ch] = 0;
        rnd_v = 3'b000;
        for (int t = 0; t < 1500; t++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    rnd_v[ch] = 1'($urandom_range(0, 1));
                    hold[ch]  = int'($urandom_range(1, 9));
                end
                hold[ch]--;
            end
            sw_in = rnd_v;
            if ($urandom_range(0, 299) == 0) reset_pulse();
            else step(1);
        end

        step(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
